// File: rtl/bitcount_scheduler_if.sv
// Request/operand bus between requesters and the shared popcount scheduler.
interface bitcount_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned IDW   = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] operand;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [CW-1:0]          result;

    modport master (
        output req, operand,
        input  grant, busy, done, done_id, result
    );

    modport slave (
        input  req, operand,
        output grant, busy, done, done_id, result
    );
endinterface

// File: rtl/bitcount_scheduler.sv
// Round-robin shared shift-and-count popcount engine: grants one requester,
// counts the set bits of its operand and returns the count tagged with its ID.
module bitcount_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    bitcount_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [CW-1:0]      result_q, result_d;

    logic               win_valid_c;
    logic [IDW-1:0]     win_id_c;
    logic [IDW-1:0]     idx_c;
    logic [WIDTH-1:0]   win_op_c;

    // Round-robin pick: first asserted request at or after the pointer, wrapping.
    always_comb begin
        win_valid_c = 1'b0;
        win_id_c    = '0;
        idx_c       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx_c = ptr_q + IDW'(i);
            if (!win_valid_c && bus.req[idx_c]) begin
                win_valid_c = 1'b1;
                win_id_c    = idx_c;
            end
        end
        win_op_c = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (IDW'(j) == win_id_c) begin
                win_op_c = bus.operand[j*WIDTH +: WIDTH];
            end
        end
    end

    // Sequencing FSM and shared shift/count datapath.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        result_d  = result_q;
        grant_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    sr_d    = win_op_c;
                    cnt_d   = '0;
                    id_d    = win_id_c;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sr_q == '0) begin
                    result_d  = cnt_q;
                    done_id_d = id_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(sr_q[0]);
                    sr_d  = sr_q >> 1;
                end
            end
            DONE: begin
                ptr_d   = id_q + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d != IDLE) begin
            grant_d[id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Directed plus randomized bench for bitcount_scheduler against a job-level
// reference model (round-robin pick, popcount, MSB-derived latency).
module tb_bitcount_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned IDW   = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bitcount_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CW(CW), .IDW(IDW)) bus ();

    bitcount_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CW(CW), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: round-robin pointer and last reported completion.
    int ptr_m;
    int last_id;
    int last_res;

    function automatic int popcnt(input logic [WIDTH-1:0] v);
        int c = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (v[i]) c++;
        return c;
    endfunction

    // Edges from the sampling edge up to and including the one raising done.
    function automatic int job_latency(input logic [WIDTH-1:0] v);
        for (int i = int'(WIDTH) - 1; i >= 0; i--) if (v[i]) return i + 3;
        return 2;
    endfunction

    function automatic int pick(input logic [N_REQ-1:0] r, input int p);
        for (int i = 0; i < int'(N_REQ); i++) begin
            int k;
            k = (p + i) % int'(N_REQ);
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] v);
        bus.operand[i*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [WIDTH-1:0] get_op(input int i);
        return bus.operand[i*WIDTH +: WIDTH];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".grant"},   32'(bus.grant),   32'd0);
        chk({tag, ".busy"},    32'(bus.busy),    32'd0);
        chk({tag, ".done"},    32'(bus.done),    32'd0);
        chk({tag, ".done_id"}, 32'(bus.done_id), 32'd0);
        chk({tag, ".result"},  32'(bus.result),  32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        check_reset_outputs("reset");
        reset    = 1'b0;
        ptr_m    = 0;
        last_id  = 0;
        last_res = 0;
    endtask

    // One full job from the sampling edge through DONE and back to IDLE.
    task automatic do_round(input string tag, input bit drop, input bit scramble);
        int w, lat, res;
        logic [WIDTH-1:0] op;
        w = pick(bus.req, ptr_m);
        if (w < 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s.no_request observed=0 expected=nonzero", tag);
            return;
        end
        op  = get_op(w);
        lat = job_latency(op);
        res = popcnt(op);
        for (int n = 1; n <= lat; n++) begin
            tick();
            if (n == 1 && scramble) set_op(w, WIDTH'($urandom));
            chk({tag, ".grant"}, 32'(bus.grant), 32'(1) << w);
            chk({tag, ".busy"},  32'(bus.busy),  32'd1);
            chk({tag, ".done"},  32'(bus.done),  32'(n == lat));
            if (n == lat) begin
                chk({tag, ".done_id"}, 32'(bus.done_id), 32'(w));
                chk({tag, ".result"},  32'(bus.result),  32'(res));
            end else begin
                chk({tag, ".held_id"},  32'(bus.done_id), 32'(last_id));
                chk({tag, ".held_res"}, 32'(bus.result),  32'(last_res));
            end
        end
        last_id  = w;
        last_res = res;
        ptr_m    = (w + 1) % int'(N_REQ);
        if (drop) bus.req[w] = 1'b0;
        tick();
        chk({tag, ".idle_grant"}, 32'(bus.grant),   32'd0);
        chk({tag, ".idle_busy"},  32'(bus.busy),    32'd0);
        chk({tag, ".idle_done"},  32'(bus.done),    32'd0);
        chk({tag, ".idle_id"},    32'(bus.done_id), 32'(last_id));
        chk({tag, ".idle_res"},   32'(bus.result),  32'(last_res));
    endtask

    initial begin
        reset       = 1'b1;
        bus.req     = '0;
        bus.operand = '0;

        // Single job, small operand.
        do_reset(2);
        set_op(0, 8'h03);
        bus.req = 4'b0001;
        do_round("t1", 1'b1, 1'b0);

        // All-ones operand: longest job.
        set_op(1, 8'hFF);
        bus.req = 4'b0010;
        do_round("t2", 1'b1, 1'b0);

        // Zero operand: shortest job.
        set_op(2, 8'h00);
        bus.req = 4'b0100;
        do_round("t3", 1'b1, 1'b0);

        // All four requesting at once, served in order.
        do_reset(2);
        set_op(0, 8'h01);
        set_op(1, 8'h03);
        set_op(2, 8'h07);
        set_op(3, 8'h0F);
        bus.req = 4'b1111;
        for (int j = 0; j < 4; j++) do_round("t4", 1'b1, 1'b0);

        // Two requesters held high continuously alternate.
        do_reset(2);
        set_op(0, 8'h80);
        set_op(2, 8'h01);
        bus.req = 4'b0101;
        for (int j = 0; j < 3; j++) do_round("t5", 1'b0, 1'b0);
        do_round("t5", 1'b1, 1'b0);
        bus.req = '0;

        // Reset mid-SHIFT aborts the job; pointer returns to 0.
        do_reset(2);
        set_op(2, 8'h00);
        bus.req = 4'b0100;
        do_round("t6pre", 1'b1, 1'b0);
        set_op(3, 8'hFF);
        set_op(0, 8'h5A);
        bus.req = 4'b1001;
        tick();
        chk("t6.grant3", 32'(bus.grant), 32'h8);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("t6.abort");
        reset    = 1'b0;
        ptr_m    = 0;
        last_id  = 0;
        last_res = 0;
        do_round("t6.after", 1'b1, 1'b0);
        do_round("t6.req3", 1'b1, 1'b0);
        bus.req = '0;

        // Randomized traffic with operand changes after the latch edge.
        do_reset(1);
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!bus.req[i]) set_op(i, WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1));
            end
            bus.req = bus.req | N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            if (bus.req == '0) bus.req[$urandom_range(0, N_REQ - 1)] = 1'b1;
            do_round("rand", 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
